// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter
//   Shares one two-stage registered multiplier between NUM_REQ requesters.
//   A round-robin arbiter accepts at most one operand pair per cycle
//   (valid/ready), and the product comes back two cycles after the transfer,
//   tagged with the index of the requester that issued it.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        synchronous reset, active high
//   req_valid_i  [NUM_REQ]       requester i has operands
//   req_ready_o  [NUM_REQ]       requester i accepted this cycle (one-hot or zero)
//   req_a_i      [NUM_REQ*DW1]   operand A, requester i at [i*DW1 +: DW1]
//   req_b_i      [NUM_REQ*DW2]   operand B, requester i at [i*DW2 +: DW2]
//   res_valid_o                  product valid this cycle
//   res_id_o     [ID_WIDTH]      requester owning res_data_o
//   res_data_o   [DW1+DW2]       full-precision product
//   busy_o                       an operation is in flight in the pipeline
module mult_rr_arbiter #(
   parameter int SIGNED       = 1,
   parameter int DATA_WIDTH_1 = 16,
   parameter int DATA_WIDTH_2 = 16,
   parameter int NUM_REQ      = 4,
   parameter int ID_WIDTH     = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NUM_REQ-1:0]                   req_valid_i,
   output logic [NUM_REQ-1:0]                   req_ready_o,
   input  logic [NUM_REQ*DATA_WIDTH_1-1:0]      req_a_i,
   input  logic [NUM_REQ*DATA_WIDTH_2-1:0]      req_b_i,
   output logic                                 res_valid_o,
   output logic [ID_WIDTH-1:0]                  res_id_o,
   output logic [DATA_WIDTH_1+DATA_WIDTH_2-1:0] res_data_o,
   output logic                                 busy_o
);

   localparam int PW = DATA_WIDTH_1 + DATA_WIDTH_2;

   logic [ID_WIDTH-1:0]     ptr_q;
   logic                    gnt_found;
   logic [ID_WIDTH-1:0]     gnt_idx;
   logic [NUM_REQ-1:0]      ready_d;

   logic                    s1_v_q;
   logic [DATA_WIDTH_1-1:0] s1_a_q;
   logic [DATA_WIDTH_2-1:0] s1_b_q;
   logic [ID_WIDTH-1:0]     s1_id_q;

   logic                    s2_v_q;
   logic [ID_WIDTH-1:0]     s2_id_q;
   logic [PW-1:0]           s2_prod_q;

   logic [PW-1:0]           ext_a;
   logic [PW-1:0]           ext_b;
   logic [PW-1:0]           prod_d;

   // Search starts one past the last winner and wraps, so the most recent
   // winner has the lowest priority next time.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      ready_d   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int idx;
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_found && req_valid_i[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_WIDTH'(idx);
         end
      end
      if (gnt_found && !rst_i) ready_d[gnt_idx] = 1'b1;
   end

   assign req_ready_o = ready_d;

   // Extending both operands to the full product width and keeping only the
   // low PW bits of the product gives the exact result in either mode.
   always_comb begin
      if (SIGNED != 0) begin
         ext_a = {{DATA_WIDTH_2{s1_a_q[DATA_WIDTH_1-1]}}, s1_a_q};
         ext_b = {{DATA_WIDTH_1{s1_b_q[DATA_WIDTH_2-1]}}, s1_b_q};
      end else begin
         ext_a = {{DATA_WIDTH_2{1'b0}}, s1_a_q};
         ext_b = {{DATA_WIDTH_1{1'b0}}, s1_b_q};
      end
      prod_d = ext_a * ext_b;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q     <= ID_WIDTH'(NUM_REQ - 1);
         s1_v_q    <= 1'b0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_id_q   <= '0;
         s2_v_q    <= 1'b0;
         s2_id_q   <= '0;
         s2_prod_q <= '0;
      end else begin
         s1_v_q <= gnt_found;
         if (gnt_found) begin
            ptr_q   <= gnt_idx;
            s1_a_q  <= req_a_i[gnt_idx*DATA_WIDTH_1 +: DATA_WIDTH_1];
            s1_b_q  <= req_b_i[gnt_idx*DATA_WIDTH_2 +: DATA_WIDTH_2];
            s1_id_q <= gnt_idx;
         end
         s2_v_q <= s1_v_q;
         // Result registers hold their last value while idle.
         if (s1_v_q) begin
            s2_prod_q <= prod_d;
            s2_id_q   <= s1_id_q;
         end
      end
   end

   assign res_valid_o = s2_v_q;
   assign res_id_o    = s2_id_q;
   assign res_data_o  = s2_prod_q;
   assign busy_o      = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
module tb_mult_rr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  req_ready, req_ready_u;
   logic        res_valid, res_valid_u;
   logic [1:0]  res_id, res_id_u;
   logic [31:0] res_data, res_data_u;
   logic        busy, busy_u;

   int tests  = 0;
   int failed = 0;

   mult_rr_arbiter #(.SIGNED(1), .DATA_WIDTH_1(16), .DATA_WIDTH_2(16),
                     .NUM_REQ(4), .ID_WIDTH(2)) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_a_i(req_a), .req_b_i(req_b), .res_valid_o(res_valid), .res_id_o(res_id),
      .res_data_o(res_data), .busy_o(busy));

   mult_rr_arbiter #(.SIGNED(0), .DATA_WIDTH_1(16), .DATA_WIDTH_2(16),
                     .NUM_REQ(4), .ID_WIDTH(2)) dut_u (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_u),
      .req_a_i(req_a), .req_b_i(req_b), .res_valid_o(res_valid_u), .res_id_o(res_id_u),
      .res_data_o(res_data_u), .busy_o(busy_u));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  exp_ready;
      logic        exp_rv;
      logic [1:0]  exp_id;
      logic [31:0] exp_data;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic set_all_ops(input logic [15:0] a, input logic [15:0] b);
      for (int i = 0; i < 4; i++) begin
         req_a[i*16 +: 16] = a;
         req_b[i*16 +: 16] = b;
      end
   endtask

   function automatic logic [31:0] sprod(input logic [15:0] a, input logic [15:0] b);
      int pa, pb;
      pa = int'($signed(a));
      pb = int'($signed(b));
      return 32'(pa * pb);
   endfunction

   // random-run model state
   logic        pend_v[4];
   logic [15:0] pend_a[4];
   logic [15:0] pend_b[4];
   int          m_ptr;
   logic        e1_v, e2_v;
   logic [1:0]  e1_id, e2_id;
   logic [31:0] e1_d, e2_d;

   initial begin
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
      next_cycle();
      next_cycle();

      // reset behaviour: ready held low while rst is high, clean state after
      rst = 1'b1; req_valid = 4'b1111;
      #2 check("ready_in_rst", 32'(req_ready), 32'h0);
      next_cycle();
      rst = 1'b0; req_valid = '0;
      #2;
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_res_valid", 32'(res_valid), 32'h0);
      check("rst_res_id", 32'(res_id), 32'h0);
      check("rst_res_data", res_data, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      next_cycle();

      // table-driven vectors, starting from a fresh reset (ptr = 3)
      vecs[0]  = '{4'b0001, 16'hFFFD, 16'd7,    4'b0001, 1'b0, 2'd0, 32'h0,        1'b0};
      vecs[1]  = '{4'b0000, 16'h0,    16'h0,    4'b0000, 1'b0, 2'd0, 32'h0,        1'b1};
      vecs[2]  = '{4'b0000, 16'h0,    16'h0,    4'b0000, 1'b1, 2'd0, 32'hFFFFFFEB, 1'b1};
      vecs[3]  = '{4'b1111, 16'd2,    16'd3,    4'b0010, 1'b0, 2'd0, 32'h0,        1'b0};
      vecs[4]  = '{4'b1111, 16'd4,    16'd5,    4'b0100, 1'b0, 2'd0, 32'h0,        1'b1};
      vecs[5]  = '{4'b1111, 16'hFFFF, 16'hFFFF, 4'b1000, 1'b1, 2'd1, 32'd6,        1'b1};
      vecs[6]  = '{4'b1111, 16'h7FFF, 16'h8000, 4'b0001, 1'b1, 2'd2, 32'd20,       1'b1};
      vecs[7]  = '{4'b0000, 16'h0,    16'h0,    4'b0000, 1'b1, 2'd3, 32'd1,        1'b1};
      vecs[8]  = '{4'b0000, 16'h0,    16'h0,    4'b0000, 1'b1, 2'd0, 32'hC0008000, 1'b1};
      vecs[9]  = '{4'b0100, 16'h0,    16'd1234, 4'b0100, 1'b0, 2'd0, 32'h0,        1'b0};
      vecs[10] = '{4'b1000, 16'h8000, 16'h8000, 4'b1000, 1'b0, 2'd0, 32'h0,        1'b1};
      vecs[11] = '{4'b0000, 16'h0,    16'h0,    4'b0000, 1'b1, 2'd2, 32'h0,        1'b1};
      vecs[12] = '{4'b0000, 16'h0,    16'h0,    4'b0000, 1'b1, 2'd3, 32'h40000000, 1'b1};
      vecs[13] = '{4'b0000, 16'h0,    16'h0,    4'b0000, 1'b0, 2'd0, 32'h0,        1'b0};
      do_reset();
      for (int v = 0; v < 14; v++) begin
         req_valid = vecs[v].valid;
         set_all_ops(vecs[v].a, vecs[v].b);
         #2;
         check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
         check($sformatf("vec%0d_res_valid", v), 32'(res_valid), 32'(vecs[v].exp_rv));
         check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
         if (vecs[v].exp_rv) begin
            check($sformatf("vec%0d_res_id", v), 32'(res_id), 32'(vecs[v].exp_id));
            check($sformatf("vec%0d_res_data", v), res_data, vecs[v].exp_data);
         end
         next_cycle();
      end

      // all requesters valid: rotation 0,1,2,3,... and results in the same order
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_a[i*16 +: 16] = 16'(i + 1);
         req_b[i*16 +: 16] = 16'(i + 10);
      end
      for (int c = 0; c < 10; c++) begin
         req_valid = (c < 8) ? 4'b1111 : 4'b0000;
         #2;
         if (c < 8) check($sformatf("rot%0d_ready", c), 32'(req_ready), 32'(1 << (c % 4)));
         if (c >= 2) begin
            check($sformatf("rot%0d_res_valid", c), 32'(res_valid), 32'h1);
            check($sformatf("rot%0d_res_id", c), 32'(res_id), 32'((c - 2) % 4));
            check($sformatf("rot%0d_res_data", c), res_data,
                  32'((((c - 2) % 4) + 1) * (((c - 2) % 4) + 10)));
         end
         next_cycle();
      end

      // wrap: ptr=1, 1001 -> grants 3, 0, 3
      do_reset();
      set_all_ops(16'd1, 16'd1);
      req_valid = 4'b0010;
      #2 check("wrap_setup", 32'(req_ready), 32'b0010);
      next_cycle();
      req_valid = 4'b1001;
      #2 check("wrap_g3", 32'(req_ready), 32'b1000);
      next_cycle();
      #2 check("wrap_g0", 32'(req_ready), 32'b0001);
      next_cycle();
      #2 check("wrap_g3b", 32'(req_ready), 32'b1000);
      next_cycle();

      // signed vs unsigned with all-ones operands
      do_reset();
      set_all_ops(16'hFFFF, 16'hFFFF);
      req_valid = 4'b0001;
      next_cycle();
      req_valid = 4'b0000;
      next_cycle();
      #2;
      check("sgn_res_valid", 32'(res_valid), 32'h1);
      check("sgn_res_data", res_data, 32'h1);
      check("uns_res_valid", 32'(res_valid_u), 32'h1);
      check("uns_res_data", res_data_u, 32'hFFFE0001);
      next_cycle();

      // reset with two ops in flight
      do_reset();
      set_all_ops(16'd3, 16'd3);
      req_valid = 4'b1111;
      next_cycle();
      next_cycle();
      rst = 1'b1;
      #2 check("midrst_ready", 32'(req_ready), 32'h0);
      next_cycle();
      rst = 1'b0; req_valid = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         #2;
         check($sformatf("midrst%0d_res_valid", c), 32'(res_valid), 32'h0);
         check($sformatf("midrst%0d_busy", c), 32'(busy), 32'h0);
         next_cycle();
      end
      req_valid = 4'b1111;
      #2 check("midrst_next_grant", 32'(req_ready), 32'b0001);
      next_cycle();

      // requester 2 loses to 1, then wins; dropped valid leaves ptr alone
      do_reset();
      req_valid = 4'b0110;
      #2 check("hold_g1", 32'(req_ready), 32'b0010);
      next_cycle();
      req_valid = 4'b0100;
      #2 check("hold_g2", 32'(req_ready), 32'b0100);
      next_cycle();
      req_valid = 4'b0000;
      #2 check("drop_none", 32'(req_ready), 32'b0000);
      next_cycle();
      req_valid = 4'b1001;
      #2 check("drop_g3", 32'(req_ready), 32'b1000);
      next_cycle();

      // random traffic against a reference model
      do_reset();
      m_ptr = 3;
      e1_v = 1'b0; e2_v = 1'b0; e1_id = '0; e2_id = '0; e1_d = '0; e2_d = '0;
      for (int i = 0; i < 4; i++) begin
         pend_v[i] = 1'b0; pend_a[i] = '0; pend_b[i] = '0;
      end
      for (int c = 0; c < 5000; c++) begin
         int g;
         logic [3:0] exp_rdy;
         for (int i = 0; i < 4; i++) begin
            if (!pend_v[i] && ($urandom_range(0, 1) == 1)) begin
               pend_v[i] = 1'b1;
               pend_a[i] = 16'($urandom);
               pend_b[i] = 16'($urandom);
            end
            req_valid[i]      = pend_v[i];
            req_a[i*16 +: 16] = pend_a[i];
            req_b[i*16 +: 16] = pend_b[i];
         end
         g = -1;
         for (int k = 1; k <= 4; k++) begin
            if (g < 0 && pend_v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
         end
         exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
         #2;
         check("rnd_ready", 32'(req_ready), 32'(exp_rdy));
         check("rnd_res_valid", 32'(res_valid), 32'(e2_v));
         if (e2_v) begin
            check("rnd_res_id", 32'(res_id), 32'(e2_id));
            check("rnd_res_data", res_data, e2_d);
         end
         check("rnd_busy", 32'(busy), 32'(e1_v | e2_v));
         e2_v = e1_v; e2_id = e1_id; e2_d = e1_d;
         e1_v = (g >= 0);
         if (g >= 0) begin
            e1_id = 2'(g);
            e1_d  = sprod(pend_a[g], pend_b[g]);
            m_ptr = g;
            pend_v[g] = 1'b0;
         end
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
